// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/window geometry, schedule modes and the
// small sigma functions used by the message schedule and compression stages.
package sha256_pkg;

   localparam int WORD_W    = 32;
   localparam int WIN_WORDS = 16;
   localparam int WIN_W     = WORD_W * WIN_WORDS;
   localparam int T_W       = 6;

   // Schedule expansion modes; reserved behaves like full expansion.
   typedef enum logic [1:0] {
      MODE_FULL      = 2'd0,
      MODE_NO_S0     = 2'd1,
      MODE_NO_S0_W16 = 2'd2,
      MODE_RSVD      = 2'd3
   } w_mode_e;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_w_word.sv
// Single-word combinational schedule expander with term-dropping modes.
module sha256_w_word
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] w_m2,
   input  logic [WORD_W-1:0] w_m7,
   input  logic [WORD_W-1:0] w_m15,
   input  logic [WORD_W-1:0] w_m16,
   input  logic [1:0]        mode,
   input  logic              in_range,
   output logic [WORD_W-1:0] w_new
);

   logic [WORD_W-1:0] s0_term;
   logic [WORD_W-1:0] w16_term;

   // Select the optional terms per mode, then sum; words past t=63 are zero.
   always_comb begin
      s0_term  = ssig0(w_m15);
      w16_term = w_m16;
      case (w_mode_e'(mode))
         MODE_NO_S0: begin
            s0_term = '0;
         end
         MODE_NO_S0_W16: begin
            s0_term  = '0;
            w16_term = '0;
         end
         default: begin
         end
      endcase
      w_new = in_range ? (ssig1(w_m2) + w_m7 + s0_term + w16_term) : '0;
   end

endmodule

// File: rtl/sha256_w_sched_stage.sv
// SHA-256 message-schedule pipeline stage: expands NEW_W words from a
// 16-word sliding window and registers the shifted window behind a
// valid/ready handshake with a one-entry skid buffer.
module sha256_w_sched_stage
   import sha256_pkg::*;
#(
   parameter int NEW_W = 1,
   parameter int TAG_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIN_W-1:0] in_win,
   input  logic [T_W-1:0]   in_t,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIN_W-1:0] out_win,
   output logic [T_W-1:0]   out_t,
   output logic [1:0]       out_mode,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_last
);

   localparam int PAY_W = WIN_W + T_W + 2 + 1 + TAG_W;

   // ext[0..15] is the incoming window, ext[16+k] the k-th new word.
   logic [WORD_W-1:0] ext [WIN_WORDS+NEW_W];
   logic [WIN_W-1:0]  new_win;
   logic [T_W:0]      t_sum;
   logic [T_W-1:0]    new_t;
   logic              new_last;
   logic [PAY_W-1:0]  new_pay;

   genvar gj, gk;
   generate
      for (gj = 0; gj < WIN_WORDS; gj++) begin : g_unpack
         assign ext[gj] = in_win[WIN_W-1-WORD_W*gj -: WORD_W];
      end

      for (gk = 0; gk < NEW_W; gk++) begin : g_chain
         logic [T_W:0] idx;
         logic         in_range;
         assign idx      = {1'b0, in_t} + (T_W+1)'(gk);
         assign in_range = (idx <= (T_W+1)'(63));
         sha256_w_word u_word (
            .w_m2     (ext[14+gk]),
            .w_m7     (ext[9+gk]),
            .w_m15    (ext[1+gk]),
            .w_m16    (ext[gk]),
            .mode     (in_mode),
            .in_range (in_range),
            .w_new    (ext[WIN_WORDS+gk])
         );
      end

      for (gj = 0; gj < WIN_WORDS; gj++) begin : g_pack
         assign new_win[WIN_W-1-WORD_W*gj -: WORD_W] = ext[NEW_W+gj];
      end
   endgenerate

   // t_sum reaching 64 means word 63 was produced; out_t saturates there.
   assign t_sum    = {1'b0, in_t} + (T_W+1)'(NEW_W);
   assign new_last = t_sum[T_W];
   assign new_t    = t_sum[T_W] ? {T_W{1'b1}} : t_sum[T_W-1:0];
   assign new_pay  = {new_win, new_t, in_mode, new_last, in_tag};

   logic             out_valid_q, out_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [PAY_W-1:0] out_pay_q, out_pay_d;
   logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
   logic             in_fire;

   assign in_ready = ~skid_valid_q;
   assign in_fire  = in_valid & in_ready;

   // Output register refills from skid first, then from input; a stalled
   // output diverts an accepted input into the skid entry.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_pay_d    = out_pay_q;
      skid_valid_d = skid_valid_q;
      skid_pay_d   = skid_pay_q;
      if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_pay_d    = skid_pay_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_pay_d   = new_pay;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_pay_d   = new_pay;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_pay_q    <= '0;
         skid_pay_q   <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_pay_q    <= out_pay_d;
         skid_pay_q   <= skid_pay_d;
      end
   end

   assign out_valid = out_valid_q;
   assign {out_win, out_t, out_mode, out_last, out_tag} = out_pay_q;

endmodule

// File: tb/tb_sha256_w_sched_stage.sv
// Self-checking bench for sha256_w_sched_stage (NEW_W=2 and NEW_W=4 instances).
module tb_sha256_w_sched_stage;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   // DUT a: NEW_W=2
   logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
   logic [511:0] in_win_a, out_win_a;
   logic [5:0]   in_t_a, out_t_a;
   logic [1:0]   in_mode_a, out_mode_a;
   logic [7:0]   in_tag_a, out_tag_a;

   // DUT b: NEW_W=4
   logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
   logic [511:0] in_win_b, out_win_b;
   logic [5:0]   in_t_b, out_t_b;
   logic [1:0]   in_mode_b, out_mode_b;
   logic [7:0]   in_tag_b, out_tag_b;

   sha256_w_sched_stage #(.NEW_W(2), .TAG_W(8)) dut_a (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_win(in_win_a),
      .in_t(in_t_a), .in_mode(in_mode_a), .in_tag(in_tag_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_win(out_win_a),
      .out_t(out_t_a), .out_mode(out_mode_a), .out_tag(out_tag_a),
      .out_last(out_last_a)
   );

   sha256_w_sched_stage #(.NEW_W(4), .TAG_W(8)) dut_b (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_win(in_win_b),
      .in_t(in_t_b), .in_mode(in_mode_b), .in_tag(in_tag_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_win(out_win_b),
      .out_t(out_t_b), .out_mode(out_mode_b), .out_tag(out_tag_b),
      .out_last(out_last_b)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [511:0] win;
      logic [5:0]   t;
      logic [1:0]   mode;
      logic         last;
      logic [7:0]   tag;
   } exp_t;

   logic [31:0] fips [64];

   // in_t below 16 is a protocol violation on either stage
   always @(posedge CLK) begin
      if (RST) begin
         assert (!(in_valid_a && in_t_a < 6'd16)) else $error("[TB] in_t below 16 on dut_a");
         assert (!(in_valid_b && in_t_b < 6'd16)) else $error("[TB] in_t below 16 on dut_b");
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
   endfunction

   // Reference: shift the window by n, appending schedule words by the recurrence
   function automatic logic [511:0] model_step(input logic [511:0] win, input int t, input int mode, input int n);
      logic [31:0]  w [20];
      logic [31:0]  acc;
      logic [511:0] r;
      for (int j = 0; j < 16; j++) w[j] = win[511-32*j -: 32];
      for (int k = 0; k < n; k++) begin
         if (t + k > 63) begin
            w[16+k] = 32'h0;
         end else begin
            acc = s1(w[14+k]) + w[9+k];
            if (mode != 1 && mode != 2) acc = acc + s0(w[1+k]);
            if (mode != 2) acc = acc + w[k];
            w[16+k] = acc;
         end
      end
      for (int j = 0; j < 16; j++) r[511-32*j -: 32] = w[n+j];
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [511:0] win, input int t, input int mode, input logic [7:0] tag, input logic valid);
      in_win_a   = win;
      in_t_a     = 6'(t);
      in_mode_a  = 2'(mode);
      in_tag_a   = tag;
      in_valid_a = valid;
   endtask

   initial begin
      logic [511:0] abc_win, cur, expw;
      logic [7:0]   tagv;
      int           accepted;
      logic         ready_seen [3];
      logic [7:0]   exp_tags [$];
      logic [7:0]   got_tags [$];
      exp_t         sb [$];
      exp_t         e;
      logic [511:0] rw;
      int           rt, rm;

      abc_win = {32'h61626380, 448'h0, 32'h00000018};
      for (int i = 0; i < 16; i++) fips[i] = abc_win[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         fips[i] = s1(fips[i-2]) + fips[i-7] + s0(fips[i-15]) + fips[i-16];

      RST = 1'b0;
      applyStimulus(abc_win, 16, 0, 8'h00, 1'b0);
      out_ready_a = 1'b1;
      in_valid_b = 1'b0; in_win_b = '0; in_t_b = 6'd16; in_mode_b = 2'd0; in_tag_b = 8'h0;
      out_ready_b = 1'b1;
      #1;
      checkOutput("rst_out_valid", out_valid_a, 1'b0);
      checkOutput("rst_in_ready", in_ready_a, 1'b1);
      checkOutput("rst_out_win", out_win_a, 512'h0);
      checkOutput("rst_out_t", out_t_a, 6'd0);
      checkOutput("rst_out_last", out_last_a, 1'b0);
      checkOutput("rst_out_tag", out_tag_a, 8'h0);
      tick();
      RST = 1'b1;
      tick();

      // "abc" block, mode 0
      applyStimulus(abc_win, 16, 0, 8'h11, 1'b1);
      tick();
      in_valid_a = 1'b0;
      checkOutput("abc_valid", out_valid_a, 1'b1);
      checkOutput("abc_w14", out_win_a[63:32], 32'h61626380);
      checkOutput("abc_w15", out_win_a[31:0], 32'h000F0000);
      checkOutput("abc_win", out_win_a, {32'h0, 384'h0, 32'h00000018, 32'h61626380, 32'h000F0000});
      checkOutput("abc_t", out_t_a, 6'd18);
      checkOutput("abc_last", out_last_a, 1'b0);
      checkOutput("abc_tag", out_tag_a, 8'h11);
      tick();
      checkOutput("abc_drained", out_valid_a, 1'b0);

      // "abc" block, mode 2
      applyStimulus(abc_win, 16, 2, 8'h22, 1'b1);
      tick();
      in_valid_a = 1'b0;
      checkOutput("m2_w14", out_win_a[63:32], 32'h00000000);
      checkOutput("m2_w15", out_win_a[31:0], 32'h000F0000);
      checkOutput("m2_mode", out_mode_a, 2'd2);
      tick();

      // 24 chained transfers from t=16
      cur = abc_win;
      for (int i = 0; i < 24; i++) begin
         applyStimulus(cur, 16 + 2*i, 0, 8'(i), 1'b1);
         tick();
         checkOutput("chain_valid", out_valid_a, 1'b1);
         checkOutput("chain_last", out_last_a, (16 + 2*i) == 62);
         cur = out_win_a;
      end
      in_valid_a = 1'b0;
      for (int j = 0; j < 16; j++) expw[511-32*j -: 32] = fips[48+j];
      checkOutput("chain_final_win", cur, expw);
      checkOutput("chain_final_t", out_t_a, 6'd63);
      tick();

      // Range limit on NEW_W=4 at t=62
      for (int j = 0; j < 16; j++) in_win_b[511-32*j -: 32] = fips[46+j];
      in_t_b = 6'd62; in_mode_b = 2'd0; in_tag_b = 8'h5A; in_valid_b = 1'b1;
      tick();
      in_valid_b = 1'b0;
      for (int j = 0; j < 14; j++) expw[511-32*j -: 32] = fips[50+j];
      expw[63:0] = 64'h0;
      checkOutput("range_win", out_win_b, expw);
      checkOutput("range_t", out_t_b, 6'd63);
      checkOutput("range_last", out_last_b, 1'b1);
      tick();

      // Backpressure: out_ready low for 3 cycles, in_valid held
      out_ready_a = 1'b0;
      accepted = 0;
      tagv = 8'h40;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(abc_win, 16, 0, tagv, 1'b1);
         ready_seen[c] = in_ready_a;
         if (in_ready_a) begin
            exp_tags.push_back(tagv);
            accepted++;
            tagv = tagv + 8'h1;
         end
         tick();
      end
      checkOutput("bp_ready_c0", ready_seen[0], 1'b1);
      checkOutput("bp_ready_c1", ready_seen[1], 1'b1);
      checkOutput("bp_ready_c2", ready_seen[2], 1'b0);
      checkOutput("bp_accepted", 32'(accepted), 32'd2);
      checkOutput("bp_in_ready", in_ready_a, 1'b0);
      checkOutput("bp_hold_tag", out_tag_a, 8'h40);
      in_valid_a = 1'b0;
      out_ready_a = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (out_valid_a) got_tags.push_back(out_tag_a);
         tick();
      end
      checkOutput("bp_count", 32'(got_tags.size()), 32'(exp_tags.size()));
      for (int i = 0; i < exp_tags.size() && i < got_tags.size(); i++)
         checkOutput("bp_order", got_tags[i], exp_tags[i]);

      // Randomized traffic on NEW_W=4 against a scoreboard
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int j = 0; j < 16; j++) rw[511-32*j -: 32] = $urandom;
         rt = $urandom_range(63, 16);
         rm = $urandom_range(3, 0);
         in_win_b    = rw;
         in_t_b      = 6'(rt);
         in_mode_b   = 2'(rm);
         in_tag_b    = 8'($urandom);
         in_valid_b  = ($urandom_range(3, 0) != 0);
         out_ready_b = ($urandom_range(3, 0) != 0);
         if (out_valid_b && out_ready_b) begin
            if (sb.size() == 0) begin
               checkOutput("rnd_spurious", out_valid_b, 1'b0);
            end else begin
               e = sb.pop_front();
               checkOutput("rnd_win", out_win_b, e.win);
               checkOutput("rnd_t", out_t_b, e.t);
               checkOutput("rnd_mode", out_mode_b, e.mode);
               checkOutput("rnd_last", out_last_b, e.last);
               checkOutput("rnd_tag", out_tag_b, e.tag);
            end
         end
         if (in_valid_b && in_ready_b) begin
            e.win  = model_step(rw, rt, rm, 4);
            e.t    = (rt + 4 > 63) ? 6'd63 : 6'(rt + 4);
            e.mode = 2'(rm);
            e.last = (rt + 4 - 1 >= 63);
            e.tag  = in_tag_b;
            sb.push_back(e);
         end
         tick();
      end
      in_valid_b  = 1'b0;
      out_ready_b = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (out_valid_b) begin
            if (sb.size() == 0) begin
               checkOutput("drain_spurious", out_valid_b, 1'b0);
            end else begin
               e = sb.pop_front();
               checkOutput("drain_win", out_win_b, e.win);
               checkOutput("drain_tag", out_tag_b, e.tag);
            end
         end
         tick();
      end
      checkOutput("drain_empty", 32'(sb.size()), 32'd0);
      checkOutput("drain_idle", out_valid_b, 1'b0);

      // Asynchronous reset while output and skid are both full
      out_ready_a = 1'b0;
      applyStimulus(abc_win, 20, 0, 8'h70, 1'b1);
      tick();
      in_tag_a = 8'h71;
      tick();
      in_valid_a = 1'b0;
      checkOutput("rst2_skid_full", in_ready_a, 1'b0);
      checkOutput("rst2_pre_valid", out_valid_a, 1'b1);
      #3;
      RST = 1'b0;
      #1;
      checkOutput("rst2_out_valid", out_valid_a, 1'b0);
      checkOutput("rst2_in_ready", in_ready_a, 1'b1);
      checkOutput("rst2_out_win", out_win_a, 512'h0);
      checkOutput("rst2_out_tag", out_tag_a, 8'h0);
      checkOutput("rst2_out_t", out_t_a, 6'd0);
      checkOutput("rst2_out_mode", out_mode_a, 2'd0);
      checkOutput("rst2_out_last", out_last_a, 1'b0);
      tick();
      RST = 1'b1;
      out_ready_a = 1'b1;
      applyStimulus(abc_win, 16, 0, 8'h7A, 1'b1);
      tick();
      in_valid_a = 1'b0;
      checkOutput("post_rst_valid", out_valid_a, 1'b1);
      checkOutput("post_rst_tag", out_tag_a, 8'h7A);
      checkOutput("post_rst_win", out_win_a, model_step(abc_win, 16, 0, 2));
      tick();
      checkOutput("post_rst_nodup", out_valid_a, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
